// File: rtl/mac_operand_sequencer_if.sv
// Bundle between the operand sequencer and its neighbours: the byte load
// port, the stream request/status signals, and the operand bus into the MAC.
//
// Load handshake: a byte transfers on a rising clock edge where load_valid
// and load_ready are both high. load_ready depends only on the sequencer's
// own state (never on load_valid), and a byte offered while load_ready is
// low is simply not taken; the driver may hold or change it freely.
interface mac_operand_sequencer_if #(
  parameter int LEN_W = 3
);
  logic             load_valid;
  logic [7:0]       load_data;
  logic             load_ready;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             mac_enable;
  logic [7:0]       mac_a;
  logic [7:0]       mac_b;
  logic             done;
  logic             start_err;

  // Sequencer side
  modport slave (
    input  load_valid, load_data, start, len,
    output load_ready, busy, mac_enable, mac_a, mac_b, done, start_err
  );

  // Driver / consumer side
  modport master (
    output load_valid, load_data, start, len,
    input  load_ready, busy, mac_enable, mac_a, mac_b, done, start_err
  );
endinterface

// File: rtl/mac_operand_sequencer.sv
// Operand feeder for an 8x8->16 accumulate MAC. Bytes arrive a0,b0,a1,b1,...
// into a small pair buffer; a start request then streams the first len pairs
// into the MAC on consecutive cycles and pulses done in the cycle where the
// MAC accumulator holds the finished dot product.
module mac_operand_sequencer #(
  parameter int DEPTH = 4,
  parameter int LEN_W = 3,
  localparam int CNT_W = $clog2(2 * DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  mac_operand_sequencer_if.slave bus,
  output logic [1:0]            state_dbg,
  output logic [CNT_W-1:0]      count_dbg
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int SLOT_W = CNT_W - 1;
  localparam int CMP_W  = (LEN_W > CNT_W) ? LEN_W : CNT_W;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(2 * DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [IDX_W-1:0] idx;
  logic [LEN_W-1:0] rem;
  logic [7:0]       a_buf [DEPTH];
  logic [7:0]       b_buf [DEPTH];

  logic             busy_r;
  logic             enable_r;
  logic [7:0]       a_r;
  logic [7:0]       b_r;
  logic             done_r;
  logic             err_r;

  logic             loading;
  logic             ready;
  logic             load_fire;
  logic [CNT_W-2:0] pairs;
  logic             start_ok;
  logic             start_bad;
  logic [SLOT_W-1:0] slot;
  logic [IDX_W-1:0] idx_nxt;

  // Load/start decode; the pair check always sees the count before this edge's write
  always_comb begin
    loading   = (state == IDLE) || (state == FILL);
    ready     = loading && (count < FULL);
    load_fire = bus.load_valid && ready;
    pairs     = count[CNT_W-1:1];
    start_ok  = bus.start && loading && (bus.len != '0) &&
                (CMP_W'(bus.len) <= CMP_W'(pairs));
    start_bad = bus.start && loading && !start_ok;
    slot      = count[SLOT_W-1:0];
    idx_nxt   = idx + IDX_W'(1);
  end

  // Pair buffer: even slots hold a operands, odd slots hold b operands
  always_ff @(posedge clk) begin
    if (load_fire) begin
      if (slot[0]) b_buf[slot[SLOT_W-1:1]] <= bus.load_data;
      else         a_buf[slot[SLOT_W-1:1]] <= bus.load_data;
    end
  end

  // Control FSM with registered outputs; rem counts pairs left after the one on the bus
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      count    <= '0;
      idx      <= '0;
      rem      <= '0;
      busy_r   <= 1'b0;
      enable_r <= 1'b0;
      a_r      <= '0;
      b_r      <= '0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      err_r  <= start_bad;
      case (state)
        IDLE, FILL: begin
          if (load_fire) count <= count + CNT_W'(1);
          if (start_ok) begin
            // Pair 0 is already stored because len >= 1 passed against the old count
            state    <= STREAM;
            idx      <= '0;
            rem      <= bus.len - LEN_W'(1);
            busy_r   <= 1'b1;
            enable_r <= 1'b1;
            a_r      <= a_buf[0];
            b_r      <= b_buf[0];
          end else if (load_fire) begin
            state <= FILL;
          end
        end
        STREAM: begin
          if (rem == '0) begin
            state    <= FINISH;
            busy_r   <= 1'b0;
            enable_r <= 1'b0;
            a_r      <= '0;
            b_r      <= '0;
            done_r   <= 1'b1;
          end else begin
            rem <= rem - LEN_W'(1);
            idx <= idx_nxt;
            a_r <= a_buf[idx_nxt];
            b_r <= b_buf[idx_nxt];
          end
        end
        FINISH: begin
          // Buffer is consumed; a trailing unpaired byte is discarded too
          state <= IDLE;
          count <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.load_ready = ready;
  assign bus.busy       = busy_r;
  assign bus.mac_enable = enable_r;
  assign bus.mac_a      = a_r;
  assign bus.mac_b      = b_r;
  assign bus.done       = done_r;
  assign bus.start_err  = err_r;
  assign state_dbg      = state;
  assign count_dbg      = count;

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Bench for mac_operand_sequencer: a table of load/start vectors plus a few
// hand-written multi-cycle sequences. A reference accumulate MAC sits on the
// operand bus so the dot product seen at done can be checked.
module tb_mac_operand_sequencer;

  localparam int LEN_W = 3;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] state_dbg;
  logic [3:0] count_dbg;

  mac_operand_sequencer_if #(.LEN_W(LEN_W)) bus ();

  mac_operand_sequencer #(.DEPTH(4), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .state_dbg (state_dbg),
    .count_dbg (count_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  // Reference MAC: accumulates while enabled, clears on a clock with enable low
  logic [15:0] acc;
  always @(posedge clk) begin
    if (bus.mac_enable) acc <= acc + 16'(bus.mac_a) * 16'(bus.mac_b);
    else                acc <= '0;
  end

  typedef struct {
    int               nbytes;
    logic [0:7][7:0]  bytes;
    logic [LEN_W-1:0] len;
    logic             exp_err;
    int               exp_en;
    logic [15:0]      exp_c;
  } vec_t;

  vec_t vecs[9];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.start      = 1'b0;
    bus.len        = '0;
    reset_n        = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic load_bytes(input int n, input logic [0:7][7:0] b);
    for (int i = 0; i < n; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = b[i];
      @(negedge clk);
    end
    bus.load_valid = 1'b0;
  endtask

  task automatic pulse_start(input logic [LEN_W-1:0] l);
    bus.start = 1'b1;
    bus.len   = l;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Observes 12 cycles after the start edge; optional start poke at cycle 'poke'
  task automatic watch(input string name, input logic exp_err, input int exp_en,
                       input logic [15:0] exp_c, input int poke);
    int          en_cnt = 0;
    int          done_k = 0;
    int          done_n = 0;
    int          gap = 0;
    int          zero_bad = 0;
    int          busy_bad = 0;
    logic        err_seen = 1'b0;
    logic [15:0] c_done = '0;
    for (int k = 1; k <= 12; k++) begin
      if (bus.mac_enable === 1'b1) begin
        en_cnt++;
        if (en_cnt != k) gap = 1;
      end else if (bus.mac_a !== 8'h00 || bus.mac_b !== 8'h00) begin
        zero_bad = 1;
      end
      if (bus.busy !== bus.mac_enable) busy_bad = 1;
      if (bus.done === 1'b1) begin
        done_n++;
        if (done_k == 0) begin
          done_k = k;
          c_done = acc;
        end
      end
      if (bus.start_err === 1'b1) err_seen = 1'b1;
      bus.start = (k == poke);
      bus.len   = 1;
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk({name, "/enables"}, en_cnt, exp_en);
    chk({name, "/contiguous"}, gap, 0);
    chk({name, "/idle_zero"}, zero_bad, 0);
    chk({name, "/busy"}, busy_bad, 0);
    chk({name, "/done_cycle"}, done_k, exp_err ? 0 : exp_en + 1);
    chk({name, "/done_count"}, done_n, exp_err ? 0 : 1);
    chk({name, "/start_err"}, err_seen, exp_err);
    if (!exp_err) chk({name, "/mac_c"}, c_done, exp_c);
  endtask

  initial begin
    logic [0:7][7:0] b;
    int              dn;

    vecs[0] = '{2, {8'h02, 8'h02, 48'h0},     3'd1, 1'b0, 1, 16'h0004};
    vecs[1] = '{8, 64'h0105_0206_0307_0408,   3'd4, 1'b0, 4, 16'h0046};
    vecs[2] = '{8, 64'hFFFF_FFFF_FFFF_FFFF,   3'd4, 1'b0, 4, 16'hF804}; // 4*0xFE01 mod 2^16
    vecs[3] = '{3, {8'h01, 8'h02, 8'h03, 40'h0}, 3'd2, 1'b1, 0, 16'h0000};
    vecs[4] = '{3, {8'h01, 8'h02, 8'h03, 40'h0}, 3'd1, 1'b0, 1, 16'h0002};
    vecs[5] = '{8, 64'h0105_0206_0307_0408,   3'd0, 1'b1, 0, 16'h0000};
    vecs[6] = '{8, 64'h0105_0206_0307_0408,   3'd5, 1'b1, 0, 16'h0000};
    vecs[7] = '{6, 64'h0304_0506_0708_0000,   3'd3, 1'b0, 3, 16'h0062};
    vecs[8] = '{6, 64'h0304_0506_0708_0000,   3'd2, 1'b0, 2, 16'h002A};

    // Reset state
    do_reset();
    chk("rst/load_ready", bus.load_ready, 1);
    chk("rst/busy", bus.busy, 0);
    chk("rst/mac_enable", bus.mac_enable, 0);
    chk("rst/mac_a", bus.mac_a, 0);
    chk("rst/mac_b", bus.mac_b, 0);
    chk("rst/done", bus.done, 0);
    chk("rst/start_err", bus.start_err, 0);
    chk("rst/state", state_dbg, 0);
    chk("rst/count", count_dbg, 0);

    // Table-driven vectors
    for (int v = 0; v < 9; v++) begin
      do_reset();
      load_bytes(vecs[v].nbytes, vecs[v].bytes);
      chk($sformatf("v%0d/count_loaded", v), count_dbg, vecs[v].nbytes);
      pulse_start(vecs[v].len);
      watch($sformatf("v%0d", v), vecs[v].exp_err, vecs[v].exp_en, vecs[v].exp_c, 0);
      if (vecs[v].exp_err) begin
        chk($sformatf("v%0d/count_kept", v), count_dbg, vecs[v].nbytes);
        chk($sformatf("v%0d/state_kept", v), state_dbg, 1);
      end else begin
        chk($sformatf("v%0d/count_cleared", v), count_dbg, 0);
        chk($sformatf("v%0d/state_idle", v), state_dbg, 0);
        chk($sformatf("v%0d/ready_after", v), bus.load_ready, 1);
      end
    end

    // Nine bytes offered back-to-back: the ninth must be dropped
    do_reset();
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("ovf/ready_%0d", i), bus.load_ready, (i < 8) ? 1 : 0);
      bus.load_valid = 1'b1;
      bus.load_data  = (i < 8) ? 8'(i + 1) : 8'hAA;
      @(negedge clk);
    end
    bus.load_valid = 1'b0;
    chk("ovf/count", count_dbg, 8);
    pulse_start(3'd4);
    watch("ovf", 1'b0, 4, 16'h0064, 0);

    // Rejected start leaves the buffer intact; a legal retry then streams
    do_reset();
    b = {8'h01, 8'h02, 8'h03, 40'h0};
    load_bytes(3, b);
    pulse_start(3'd2);
    chk("retry/err_pulse", bus.start_err, 1);
    chk("retry/no_enable", bus.mac_enable, 0);
    chk("retry/count", count_dbg, 3);
    chk("retry/state", state_dbg, 1);
    @(negedge clk);
    chk("retry/err_single", bus.start_err, 0);
    pulse_start(3'd1);
    watch("retry", 1'b0, 1, 16'h0002, 0);

    // Start during STREAM is ignored silently
    do_reset();
    load_bytes(8, 64'h0105_0206_0307_0408);
    pulse_start(3'd4);
    watch("poke", 1'b0, 4, 16'h0046, 2);

    // Reset during the second stream cycle
    do_reset();
    load_bytes(8, 64'h0105_0206_0307_0408);
    pulse_start(3'd4);
    @(negedge clk);
    chk("midrst/enable_before", bus.mac_enable, 1);
    reset_n = 1'b0;
    #1;
    chk("midrst/enable_drop", bus.mac_enable, 0);
    chk("midrst/busy_drop", bus.busy, 0);
    chk("midrst/a_zero", bus.mac_a, 0);
    @(negedge clk);
    reset_n = 1'b1;
    dn = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dn++;
    end
    chk("midrst/no_done", dn, 0);
    chk("midrst/state", state_dbg, 0);
    chk("midrst/count", count_dbg, 0);
    b = {8'h02, 8'h03, 48'h0};
    load_bytes(2, b);
    pulse_start(3'd1);
    watch("midrst_after", 1'b0, 1, 16'h0006, 0);

    // Load and start on the same edge: both accepted, check uses old count
    do_reset();
    b = {8'h03, 8'h05, 48'h0};
    load_bytes(2, b);
    bus.load_valid = 1'b1;
    bus.load_data  = 8'h07;
    bus.start      = 1'b1;
    bus.len        = 3'd1;
    @(negedge clk);
    bus.load_valid = 1'b0;
    bus.start      = 1'b0;
    chk("simul/count_inc", count_dbg, 3);
    watch("simul", 1'b0, 1, 16'h000F, 0);
    chk("simul/count_cleared", count_dbg, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
